// File: rtl/phase_top.sv
// ---------------------------------------------------------------------------
// phase_top
//
// Phase generator for the quarter-wave DDS. It produces a free-running
// intra-quadrant count plus two quadrant flags. Together {s, p, cnt} form an
// (CNT_W+2)-bit up-counter that wraps every 4*2^CNT_W clocks with no dead
// cycles.
//
// Ports
//   clk  in   1      system clock, rising edge
//   rst  in   1      synchronous, active-high reset (forces Q0 / cnt = 0)
//   cnt  out  CNT_W  intra-quadrant phase count, registered
//   p    out  1      mirror flag (quadrants 1 and 3), registered
//   s    out  1      sign flag (quadrants 2 and 3), registered
// ---------------------------------------------------------------------------
module phase_top #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             p,
    output logic             s
);

    // The state encoding is chosen as (s, p), so both flags come straight
    // from the state flops with no decode logic between flop and port.
    typedef enum logic [1:0] {
        Q0 = 2'b00,  // rising positive quarter
        Q1 = 2'b01,  // falling positive quarter
        Q2 = 2'b10,  // falling negative quarter
        Q3 = 2'b11   // rising negative quarter
    } quad_t;

    quad_t            quad_p0;
    quad_t            quad_nxt;
    logic [CNT_W-1:0] cnt_p0;
    logic             wrap;

    // The count wraps on the same edge that the quadrant advances, so there
    // is never a cycle showing cnt = 0 together with the old quadrant.
    assign wrap = (cnt_p0 == {CNT_W{1'b1}});

    // ---- stage p0: count and quadrant registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0  <= '0;
            quad_p0 <= Q0;
        end else begin
            cnt_p0  <= cnt_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
            quad_p0 <= quad_nxt;
        end
    end

    always_comb begin
        quad_nxt = quad_p0;
        if (wrap) begin
            unique case (quad_p0)
                Q0:      quad_nxt = Q1;
                Q1:      quad_nxt = Q2;
                Q2:      quad_nxt = Q3;
                Q3:      quad_nxt = Q0;
                default: quad_nxt = Q0;
            endcase
        end
    end

    assign cnt = cnt_p0;
    assign p   = quad_p0[0];
    assign s   = quad_p0[1];

endmodule

// File: tb/tb_phase_top.sv
module tb_phase_top;

    localparam int CNT_W = 6;
    localparam int PH_W  = CNT_W + 2;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cnt;
    logic             p;
    logic             s;

    phase_top #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .cnt (cnt),
        .p   (p),
        .s   (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              errors = 0;
    int              checks = 0;
    logic [PH_W-1:0] model  = '0;
    logic [PH_W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one edge: the reference phase is pushed when rst is applied and
    // popped/compared once the DUT has clocked it.
    task automatic step(input logic r);
        logic [PH_W-1:0] e;
        rst   = r;
        model = r ? '0 : model + 1'b1;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("phase", {24'd0, s, p, cnt}, {24'd0, e});
    endtask

    int peaks;
    int peak_edge[4];
    int peak_s[4];
    int want_edge[4];
    int want_s[4];

    initial begin
        rst = 1'b1;
        want_edge[0] = 64;  want_edge[1] = 192; want_edge[2] = 320; want_edge[3] = 448;
        want_s[0]    = 0;   want_s[1]    = 1;   want_s[2]    = 0;   want_s[3]    = 1;
        peaks = 0;
        for (int i = 0; i < 4; i++) begin
            peak_edge[i] = -1;
            peak_s[i]    = -1;
        end

        // Reset held for three edges from an arbitrary power-up state.
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_val("rst_cnt", {26'd0, cnt}, 32'd0);
            check_val("rst_ps", {30'd0, s, p}, 32'd0);
        end

        // 1024 free-running edges with targeted quadrant checks.
        for (int n = 1; n <= 1024; n++) begin
            step(1'b0);
            if (n == 1)   check_val("first_cnt", {26'd0, cnt}, 32'd1);
            if (n == 63)  check_val("e63",  {24'd0, s, p, cnt}, {24'd0, 2'b00, 6'd63});
            if (n == 64)  check_val("e64",  {24'd0, s, p, cnt}, {24'd0, 2'b01, 6'd0});
            if (n == 128) check_val("e128", {24'd0, s, p, cnt}, {24'd0, 2'b10, 6'd0});
            if (n == 192) check_val("e192", {24'd0, s, p, cnt}, {24'd0, 2'b11, 6'd0});
            if (n == 256) check_val("e256", {24'd0, s, p, cnt}, {24'd0, 2'b00, 6'd0});
            if (n == 257) check_val("e257", {24'd0, s, p, cnt}, {24'd0, 2'b00, 6'd1});
            if (n <= 512 && p === 1'b1 && cnt === '0) begin
                if (peaks < 4) begin
                    peak_edge[peaks] = n;
                    peak_s[peaks]    = int'(s);
                end
                peaks++;
            end
        end

        check_val("peak_count", peaks, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val("peak_edge", peak_edge[i], want_edge[i]);
            check_val("peak_s", peak_s[i], want_s[i]);
        end

        // Advance to Q2 with cnt = 63, then reset on the would-be wrap edge.
        for (int n = 0; n < 191; n++) step(1'b0);
        check_val("pre_wrap", {24'd0, s, p, cnt}, {24'd0, 2'b10, 6'd63});
        step(1'b1);
        check_val("rst_on_wrap", {24'd0, s, p, cnt}, 32'd0);
        for (int n = 1; n <= 3; n++) begin
            step(1'b0);
            check_val("restart", {24'd0, s, p, cnt}, n);
        end

        // Reset at an arbitrary point in Q1, then resume.
        for (int n = 0; n < 70; n++) step(1'b0);
        step(1'b1);
        check_val("rst_mid", {24'd0, s, p, cnt}, 32'd0);
        for (int n = 0; n < 300; n++) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
